exec_ctrl: RTL

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl_pkg.sv | 51 +++++
 rtl/exec_ctrl_decode.sv | 38 +++
 rtl/exec_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the exec_ctrl instruction controller: FSM states,
// decoded instruction classes, opcode/op field values and ALU operation codes.
package exec_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG,
    S_WRITE_IMM
  } state_t;

  // Instruction classes after field decode; K_ALU covers ADD and AND, whose
  // ALU operation equals the op field.
  typedef enum logic [2:0] {
    K_ILLEGAL,
    K_MOV_IMM,
    K_MOV_REG,
    K_ALU,
    K_CMP,
    K_MVN
  } kind_t;

  typedef struct packed {
    kind_t       kind;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic [1:0]  op;
    logic [15:0] sximm8;
  } dec_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_AND    = 2'b10;
  localparam logic [1:0] ALU_NOTB   = 2'b11;

endpackage

// File: rtl/exec_ctrl_decode.sv
// Combinational field extraction and legality check of the latched
// instruction word. Macro EXEC_CTRL_CMP_EN makes 101/01 (CMP) legal; without
// it CMP decodes as illegal.
module exec_ctrl_decode
  import exec_ctrl_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);

  // Split the word into fields and classify the opcode/op pair.
  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    dec.rn     = instr[10:8];
    dec.rd     = instr[7:5];
    dec.rm     = instr[2:0];
    dec.sh     = instr[4:3];
    dec.op     = instr[12:11];
    dec.sximm8 = {{8{instr[7]}}, instr[7:0]};
    dec.kind   = K_ILLEGAL;
    if (instr[15:13] == OPC_MOV) begin
      if (instr[12:11] == OP_MOV_IMM)      dec.kind = K_MOV_IMM;
      else if (instr[12:11] == OP_MOV_REG) dec.kind = K_MOV_REG;
    end else if (instr[15:13] == OPC_ALU) begin
      case (instr[12:11])
        OP_ADD, OP_AND: dec.kind = K_ALU;
        OP_MVN:         dec.kind = K_MVN;
`ifdef EXEC_CTRL_CMP_EN
        OP_CMP:         dec.kind = K_CMP;
`else
        OP_CMP:         dec.kind = K_ILLEGAL;
`endif
        default:        dec.kind = K_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle controller for a simple register-file/ALU datapath. Accepts one
// instruction at a time, sequences Moore control outputs and latches ALU
// status flags on CMP. Macro EXEC_CTRL_CMP_EN enables CMP; otherwise CMP is
// treated as illegal and the flags stay 0.
module exec_ctrl
  import exec_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  input  logic        Z,
  input  logic        V,
  input  logic        N,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n,
  output logic        done,
  output logic        err
);

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [2:0]  flags_q, flags_d;
  dec_t        dec;

  exec_ctrl_decode u_decode (
    .instr (instr_q),
    .dec   (dec)
  );

`ifndef EXEC_CTRL_CMP_EN
  // ALU flags only matter when CMP exists.
  logic unused_flags;
  assign unused_flags = Z ^ V ^ N;
`endif

  // State, latched instruction and status flags; reset clears all of them.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      flags_q <= flags_d;
    end
  end

  // Next-state logic and Moore outputs; all controls default to 0.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    flags_d     = flags_q;
    instr_ready = 1'b0;
    readnum     = '0;
    writenum    = '0;
    write       = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    vsel        = 1'b0;
    shift       = '0;
    ALUop       = ALU_ADD;
    done        = 1'b0;
    err         = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (dec.kind)
          K_MOV_IMM:        state_d = S_WRITE_IMM;
          K_MOV_REG, K_MVN: state_d = S_GET_B;
          K_ALU, K_CMP:     state_d = S_GET_A;
          default: begin
            err     = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_GET_A: begin
        readnum = dec.rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = dec.rm;
        loadb   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        shift   = dec.sh;
        state_d = S_WRITE_REG;
        case (dec.kind)
          K_MOV_REG: begin
            asel  = 1'b1;
            ALUop = ALU_ADD;
            loadc = 1'b1;
          end
          K_MVN: begin
            ALUop = ALU_NOTB;
            loadc = 1'b1;
          end
          K_ALU: begin
            ALUop = dec.op;
            loadc = 1'b1;
          end
`ifdef EXEC_CTRL_CMP_EN
          K_CMP: begin
            // Flags capture the ALU result on the edge leaving EXEC.
            ALUop   = ALU_SUB;
            done    = 1'b1;
            flags_d = {Z, V, N};
            state_d = S_IDLE;
          end
`endif
          default: state_d = S_IDLE;
        endcase
      end
      S_WRITE_REG: begin
        writenum = dec.rd;
        write    = 1'b1;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      S_WRITE_IMM: begin
        writenum = dec.rn;
        vsel     = 1'b1;
        write    = 1'b1;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sximm8                   = dec.sximm8;
  assign {flag_z, flag_v, flag_n} = flags_q;

endmodule
